l15_req_port_arbiter: RTL and testbench

Parametrised N-port request arbiter and reset-wake sequencer that sits between the L1 cache request sources (I$, D$ miss, wbuf, uncached read/write, AMO) and the single L1.5 request channel. It replaces the fixed 6-port priority scheme with these additions:
- a selectable fixed-priority or round-robin mode;
- a per-port outstanding-transaction limit, tracked with credit counters;
- a parametrised wake-up delay that gates the core reset.

---
 rtl/l15_req_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_l15_req_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/l15_req_port_arbiter.sv
// l15_req_port_arbiter: N-port request arbiter feeding the single L1.5 request
// channel, with per-port credit limits and a reset wake-up sequencer.
// Optional: define L15_ARB_STALL_CNT_EN to build the backpressure stall counter.

// Per-port outstanding-transaction counter
module l15_arb_credit #(
   parameter int CntW           = 3,
   parameter int MaxOutstanding = 4
) (
   input  logic clk_i,
   input  logic reset_l,
   input  logic inc_i,
   input  logic rsp_i,
   output logic below_o,
   output logic zero_o
);
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            dec;

   assign zero_o  = (cnt_q == '0);
   assign below_o = (cnt_q < CntW'(MaxOutstanding));
   // a response against an empty counter is an error upstream, never an underflow
   assign dec     = rsp_i & ~zero_o;

   // grant and response on the same port cancel out
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec)      cnt_d = cnt_q + CntW'(1);
      else if (dec && !inc_i) cnt_d = cnt_q - CntW'(1);
   end

   // counter register
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

module l15_req_port_arbiter #(
   parameter int NumPorts       = 6,
   parameter int DataWidth      = 128,
   parameter int MaxOutstanding = 4,
   parameter int ArbMode        = 0,
   parameter int WakeUpCycles   = 32768
) (
   input  logic                          clk_i,
   input  logic                          reset_l,
   output logic                          rst_n_o,
   input  logic [NumPorts-1:0]           req_valid_i,
   output logic [NumPorts-1:0]           req_ready_o,
   input  logic [NumPorts*DataWidth-1:0] req_data_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DataWidth-1:0]          out_data_o,
   output logic [$clog2(NumPorts)-1:0]   out_portid_o,
   input  logic                          rsp_valid_i,
   input  logic [$clog2(NumPorts)-1:0]   rsp_portid_i,
   output logic                          busy_o,
   output logic                          err_o,
   output logic [31:0]                   stall_cnt_o
);
   localparam int PidW  = $clog2(NumPorts);
   localparam int CntW  = $clog2(MaxOutstanding + 1);
   localparam int WakeW = $clog2(WakeUpCycles + 1);

   localparam logic [1:0] ST_WAKE = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [WakeW-1:0]     wake_cnt_q, wake_cnt_d;
   logic                 wake_done_q;
   logic                 wake_hit;
   logic [PidW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [DataWidth-1:0] out_data_q, out_data_d;
   logic [PidW-1:0]      out_pid_q, out_pid_d;
   logic                 err_q;

   logic [NumPorts-1:0]  elig, below, zero, rsp_hit;
   logic                 arb_en, gnt_found, gnt_vld;
   logic [PidW-1:0]      gnt_idx;
   int                   cand;

   // ---------------- wake-up sequencer ----------------
   assign wake_hit   = (wake_cnt_q == WakeW'(WakeUpCycles));
   assign wake_cnt_d = wake_hit ? wake_cnt_q : wake_cnt_q + WakeW'(1);

   // counts up to the target and holds; done rises the cycle after the hit
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         wake_cnt_q  <= '0;
         wake_done_q <= 1'b0;
      end else begin
         wake_cnt_q  <= wake_cnt_d;
         wake_done_q <= wake_done_q | wake_hit;
      end
   end

   // falls asynchronously with reset_l, rises only once wake-up is done
   assign rst_n_o = reset_l & wake_done_q;

   // ---------------- per-port credit lanes ----------------
   for (genvar p = 0; p < NumPorts; p++) begin : g_lane
      assign rsp_hit[p] = rsp_valid_i && (rsp_portid_i == PidW'(p));
      assign elig[p]    = req_valid_i[p] & below[p];
      l15_arb_credit #(.CntW(CntW), .MaxOutstanding(MaxOutstanding)) u_credit (
         .clk_i   (clk_i),
         .reset_l (reset_l),
         .inc_i   (req_ready_o[p]),
         .rsp_i   (rsp_hit[p]),
         .below_o (below[p]),
         .zero_o  (zero[p])
      );
   end

   // ---------------- arbitration ----------------
   // arbitrate when idle, or when the held request is being taken this cycle
   assign arb_en = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready_i);

   // first eligible port from the search start (0 in fixed mode, rr_ptr_q in RR)
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      for (int i = 0; i < NumPorts; i++) begin
         if (ArbMode == 1) cand = (int'(rr_ptr_q) + i) % NumPorts;
         else              cand = i;
         if (!gnt_found && elig[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = PidW'(cand);
         end
      end
   end

   assign gnt_vld     = arb_en & gnt_found;
   assign req_ready_o = gnt_vld ? (NumPorts'(1) << gnt_idx) : '0;

   // RR pointer holds the next search start; it moves past the winner on a grant
   assign rr_ptr_d = !gnt_vld ? rr_ptr_q :
                     (gnt_idx == PidW'(NumPorts - 1)) ? '0 : gnt_idx + PidW'(1);

   assign out_data_d = gnt_vld ? req_data_i[int'(gnt_idx)*DataWidth +: DataWidth] : out_data_q;
   assign out_pid_d  = gnt_vld ? gnt_idx : out_pid_q;

   // control FSM: WAKE -> IDLE -> HOLD, HOLD re-arbitrates on each handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAKE: if (wake_hit) state_d = ST_IDLE;
         ST_IDLE: if (gnt_vld)  state_d = ST_HOLD;
         ST_HOLD: if (out_ready_i) state_d = gnt_vld ? ST_HOLD : ST_IDLE;
         default: state_d = ST_WAKE;
      endcase
   end

   // state, pointer and payload registers
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         state_q    <= ST_WAKE;
         rr_ptr_q   <= '0;
         out_data_q <= '0;
         out_pid_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         out_data_q <= out_data_d;
         out_pid_q  <= out_pid_d;
      end
   end

   assign out_valid_o  = (state_q == ST_HOLD);
   assign out_data_o   = out_data_q;
   assign out_portid_o = out_pid_q;

   // ---------------- status ----------------
   // sticky error: response to an empty port, or to no port at all (out-of-range id)
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) err_q <= 1'b0;
      else if (rsp_valid_i && !(|(rsp_hit & ~zero))) err_q <= 1'b1;
   end

   assign err_o  = err_q;
   assign busy_o = (|(~zero)) | out_valid_o;

`ifdef L15_ARB_STALL_CNT_EN
   logic [31:0] stall_q;

   // saturating count of cycles the held request is backpressured
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) stall_q <= '0;
      else if (out_valid_o && !out_ready_i && (stall_q != '1)) stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_l15_req_port_arbiter.sv
// Directed bench: instance A is fixed-priority with MaxOutstanding=2, instance B
// is round-robin with MaxOutstanding=15. Both share clock and reset.
module tb_l15_req_port_arbiter;
   localparam int NP = 6;
   localparam int DW = 16;
   localparam int PW = 3;
`ifdef L15_ARB_STALL_CNT_EN
   localparam logic [31:0] STALL_EXP = 32'd10;
`else
   localparam logic [31:0] STALL_EXP = 32'd0;
`endif

   logic             clk, reset_l;
   logic [NP*DW-1:0] req_data;

   logic [NP-1:0] a_req_valid, a_req_ready;
   logic          a_rst_n, a_out_valid, a_out_ready, a_rsp_valid, a_busy, a_err;
   logic [DW-1:0] a_out_data;
   logic [PW-1:0] a_out_portid, a_rsp_portid;
   logic [31:0]   a_stall;

   logic [NP-1:0] b_req_valid, b_req_ready;
   logic          b_rst_n, b_out_valid, b_out_ready, b_rsp_valid, b_busy, b_err;
   logic [DW-1:0] b_out_data;
   logic [PW-1:0] b_out_portid, b_rsp_portid;
   logic [31:0]   b_stall;

   int nvec;
   int nfail;

   l15_req_port_arbiter #(.NumPorts(NP), .DataWidth(DW), .MaxOutstanding(2),
                          .ArbMode(0), .WakeUpCycles(16)) u_a (
      .clk_i(clk), .reset_l(reset_l), .rst_n_o(a_rst_n),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_data_i(req_data),
      .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
      .out_portid_o(a_out_portid), .rsp_valid_i(a_rsp_valid), .rsp_portid_i(a_rsp_portid),
      .busy_o(a_busy), .err_o(a_err), .stall_cnt_o(a_stall));

   l15_req_port_arbiter #(.NumPorts(NP), .DataWidth(DW), .MaxOutstanding(15),
                          .ArbMode(1), .WakeUpCycles(4)) u_b (
      .clk_i(clk), .reset_l(reset_l), .rst_n_o(b_rst_n),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_data_i(req_data),
      .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
      .out_portid_o(b_out_portid), .rsp_valid_i(b_rsp_valid), .rsp_portid_i(b_rsp_portid),
      .busy_o(b_busy), .err_o(b_err), .stall_cnt_o(b_stall));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] pay(input int p);
      return 16'hD000 + 16'(p * 16'h0111);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rsp_a(input int p);
      a_rsp_valid  = 1'b1;
      a_rsp_portid = PW'(p);
      tick();
      a_rsp_valid  = 1'b0;
   endtask

   initial begin
      nvec = 0; nfail = 0;
      reset_l = 1'b0;
      for (int p = 0; p < NP; p++) req_data[p*DW +: DW] = pay(p);
      a_req_valid = '0; a_out_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_portid = '0;
      b_req_valid = '0; b_out_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_portid = '0;
      tick(); tick();

      // reset state
      chk("rst_rst_n", a_rst_n, 0);
      chk("rst_valid", a_out_valid, 0);
      chk("rst_ready", a_req_ready, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_err", a_err, 0);
      chk("rst_stall", a_stall, 0);
      chk("rst_data", a_out_data, 0);

      // wake-up: released at cycle 0, core reset held through cycle 16
      reset_l = 1'b1;
      a_req_valid = 6'h3F;
      for (int k = 1; k <= 16; k++) begin
         tick();
         chk("wake_rst_n", a_rst_n, 0);
         chk("wake_ready", a_req_ready, 0);
      end
      a_req_valid = '0;
      tick();
      chk("wake_done", a_rst_n, 1);
      chk("wake_idle", a_out_valid, 0);

      // fixed priority, sources drop valid once accepted
      a_out_ready = 1'b1;
      a_req_valid = 6'b101010; #1;
      chk("fp_rdy1", a_req_ready, 6'b000010);
      tick(); a_req_valid = 6'b101000; #1;
      chk("fp_val1", a_out_valid, 1);
      chk("fp_pid1", a_out_portid, 1);
      chk("fp_dat1", a_out_data, pay(1));
      chk("fp_rdy3", a_req_ready, 6'b001000);
      tick(); a_req_valid = 6'b100000; #1;
      chk("fp_pid3", a_out_portid, 3);
      chk("fp_dat3", a_out_data, pay(3));
      chk("fp_rdy5", a_req_ready, 6'b100000);
      tick(); a_req_valid = '0; #1;
      chk("fp_pid5", a_out_portid, 5);
      chk("fp_dat5", a_out_data, pay(5));
      chk("fp_rdy0", a_req_ready, 0);
      tick();
      chk("fp_idle", a_out_valid, 0);
      chk("fp_busy", a_busy, 1);
      rsp_a(1); rsp_a(3); rsp_a(5);
      chk("fp_drain", a_busy, 0);
      chk("fp_err", a_err, 0);

      // credit limit on port 2 (MaxOutstanding=2)
      a_req_valid = 6'b000100; #1;
      chk("cr_g1", a_req_ready, 6'b000100);
      tick();
      chk("cr_g2", a_req_ready, 6'b000100);
      tick();
      chk("cr_full", a_req_ready, 0);
      chk("cr_hold", a_out_valid, 1);
      tick();
      chk("cr_idle", a_out_valid, 0);
      chk("cr_blk", a_req_ready, 0);
      a_rsp_valid = 1'b1; a_rsp_portid = 3'd2; #1;
      chk("cr_rspcyc", a_req_ready, 0);
      tick(); a_rsp_valid = 1'b0; #1;
      chk("cr_g3", a_req_ready, 6'b000100);
      tick();
      chk("cr_full2", a_req_ready, 0);
      a_req_valid = '0;
      tick();
      chk("cr_idle2", a_out_valid, 0);
      rsp_a(2); rsp_a(2);
      chk("cr_drain", a_busy, 0);

      // backpressure on port 0
      a_out_ready = 1'b0;
      a_req_valid = 6'b000001; #1;
      chk("bp_rdy", a_req_ready, 6'b000001);
      tick(); a_req_valid = '0;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", a_out_valid, 1);
         chk("bp_data", a_out_data, pay(0));
         tick();
      end
      chk("bp_stall", a_stall, STALL_EXP);
      chk("bp_data_end", a_out_data, pay(0));
      a_out_ready = 1'b1;
      tick();
      chk("bp_release", a_out_valid, 0);

      // grant and response on port 0 in the same cycle: count stays at 1
      a_req_valid = 6'b000001; a_rsp_valid = 1'b1; a_rsp_portid = 3'd0; #1;
      chk("sim_g", a_req_ready, 6'b000001);
      tick(); a_rsp_valid = 1'b0; #1;
      chk("sim_one_left", a_req_ready, 6'b000001);
      tick();
      chk("sim_full", a_req_ready, 0);
      a_req_valid = '0;
      tick();
      chk("sim_idle", a_out_valid, 0);
      chk("sim_err", a_err, 0);

      // response to idle port 4 sets the sticky error
      a_rsp_valid = 1'b1; a_rsp_portid = 3'd4;
      tick(); a_rsp_valid = 1'b0;
      chk("err_set", a_err, 1);
      tick(); tick(); tick();
      chk("err_sticky", a_err, 1);

      // round-robin on instance B
      chk("rr_awake", b_rst_n, 1);
      b_out_ready = 1'b1;
      b_req_valid = 6'h3F; #1;
      for (int i = 0; i < 7; i++) begin
         chk("rr_rdy", b_req_ready, 32'(1) << (i % NP));
         tick();
         chk("rr_pid", b_out_portid, i % NP);
         chk("rr_dat", b_out_data, pay(i % NP));
      end
      b_req_valid = '0;
      tick();
      chk("rr_idle", b_out_valid, 0);
      chk("rr_err0", b_err, 0);
      b_rsp_valid = 1'b1; b_rsp_portid = 3'd6;
      tick(); b_rsp_valid = 1'b0;
      chk("rr_err_oob", b_err, 1);

      // reset while holding a request on port 1
      a_out_ready = 1'b0;
      a_req_valid = 6'b000010;
      tick(); a_req_valid = '0;
      chk("mr_hold", a_out_valid, 1);
      chk("mr_busy", a_busy, 1);
      reset_l = 1'b0; #1;
      chk("mr_valid", a_out_valid, 0);
      chk("mr_rst_n", a_rst_n, 0);
      chk("mr_busy0", a_busy, 0);
      chk("mr_err", a_err, 0);
      chk("mr_stall", a_stall, 0);
      chk("mr_b_busy", b_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
